// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream (32-bit count header + payload)
// into instruction words and writes them into imem from address 0, holding the core in reset.
module imem_loader #(
    parameter int INSTR_MEM_LEN = 15,
    parameter int INSTR_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     wea,
    output logic [INSTR_MEM_LEN-1:0] addra,
    output logic [INSTR_WIDTH-1:0]   dina,
    output logic                     core_rst,
    output logic                     done,
    output logic                     err
);
    localparam int          BPW   = INSTR_WIDTH / 8;
    localparam int          CW    = INSTR_MEM_LEN + 1;
    localparam int          BCW   = $clog2((BPW > 4) ? BPW : 4);
    localparam logic [32:0] DEPTH = 33'd1 << INSTR_MEM_LEN;

    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;

    state_t                 state_q, state_d;
    logic [BCW-1:0]         byte_cnt_p0;
    logic [31:0]            hdr_p0;
    logic [INSTR_WIDTH-1:0] asm_p0;
    logic [CW-1:0]          word_idx_p0;
    logic [CW-1:0]          n_words_p0;

    logic                   xfer, hdr_take, hdr_last, data_take, word_last;
    logic [31:0]            hdr_full;
    logic [INSTR_WIDTH-1:0] word_full;

    // Status outputs are pure decodes of the state register.
    assign in_ready = (state_q == HDR) || (state_q == DATA);
    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);
    assign core_rst = (state_q != DONE);

    // A start pulse takes precedence and drops any byte offered in the same cycle.
    assign xfer      = in_valid && in_ready && !start;
    assign hdr_take  = xfer && (state_q == HDR);
    assign hdr_last  = hdr_take && (byte_cnt_p0 == BCW'(3));
    assign data_take = xfer && (state_q == DATA) && (word_idx_p0 != n_words_p0);
    assign word_last = data_take && (byte_cnt_p0 == BCW'(BPW - 1));

    always_comb begin
        hdr_full = hdr_p0;
        hdr_full[byte_cnt_p0[1:0]*8 +: 8] = in_data;
        word_full = asm_p0;
        word_full[byte_cnt_p0*8 +: 8] = in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR: begin
                if (hdr_last) begin
                    if (hdr_full == 32'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, hdr_full} > DEPTH) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // The write of the final word is in flight this cycle.
                if (wea && (word_idx_p0 == n_words_p0)) begin
                    state_d = DONE;
                end
            end
            default: begin
            end
        endcase
        if (start) begin
            state_d = HDR;
        end
    end

    // Byte assembly stage (p0) feeding the registered imem write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_p0 <= '0;
            hdr_p0      <= '0;
            asm_p0      <= '0;
            word_idx_p0 <= '0;
            n_words_p0  <= '0;
            wea         <= 1'b0;
            addra       <= '0;
            dina        <= '0;
        end else begin
            wea <= 1'b0;
            if (start) begin
                byte_cnt_p0 <= '0;
                hdr_p0      <= '0;
                asm_p0      <= '0;
                word_idx_p0 <= '0;
                n_words_p0  <= '0;
            end else if (hdr_take) begin
                hdr_p0 <= hdr_full;
                if (hdr_last) begin
                    byte_cnt_p0 <= '0;
                    n_words_p0  <= hdr_full[CW-1:0];
                end else begin
                    byte_cnt_p0 <= byte_cnt_p0 + 1'b1;
                end
            end else if (data_take) begin
                if (word_last) begin
                    wea         <= 1'b1;
                    dina        <= word_full;
                    addra       <= word_idx_p0[INSTR_MEM_LEN-1:0];
                    word_idx_p0 <= word_idx_p0 + 1'b1;
                    asm_p0      <= '0;
                    byte_cnt_p0 <= '0;
                end else begin
                    asm_p0      <= word_full;
                    byte_cnt_p0 <= byte_cnt_p0 + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a stream-level model predicts imem writes, a per-cycle
// compare process checks them, and directed scenarios pin timing with literals.
module tb_imem_loader;
    localparam int LEN = 2;
    localparam int W   = 32;
    localparam int BPW = W / 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           in_valid = 1'b0;
    logic [7:0]     in_data = 8'h00;
    logic           in_ready, wea, core_rst, done, err;
    logic [LEN-1:0] addra;
    logic [W-1:0]   dina;

    int checks = 0;
    int failures = 0;

    logic [7:0]     stream[$];
    logic [LEN-1:0] exp_addr_q[$];
    logic [W-1:0]   exp_data_q[$];
    logic [LEN-1:0] log_addr[$];
    logic [W-1:0]   log_data[$];

    imem_loader #(.INSTR_MEM_LEN(LEN), .INSTR_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wea(wea), .addra(addra), .dina(dina),
        .core_rst(core_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Model: header gives N; each complete group of BPW payload bytes is one word at index i.
    task automatic model_writes();
        logic [31:0] n;
        logic [W-1:0] w;
        n = {stream[3], stream[2], stream[1], stream[0]};
        if (n == 0 || n > (32'd1 << LEN)) return;
        for (int i = 0; i < int'(n); i++) begin
            if (4 + (i + 1) * BPW > stream.size()) break;
            w = '0;
            for (int k = 0; k < BPW; k++) w = w | (W'(stream[4 + BPW * i + k]) << (8 * k));
            exp_addr_q.push_back(LEN'(i));
            exp_data_q.push_back(w);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (wea) begin
                log_addr.push_back(addra);
                log_data.push_back(dina);
                if (exp_data_q.size() == 0) begin
                    check("unexpected_wea", wea, 0);
                end else begin
                    check("wr_addra", addra, exp_addr_q.pop_front());
                    check("wr_dina", dina, exp_data_q.pop_front());
                end
            end
            check("core_rst_only_low_in_done", core_rst, !done);
            check("ready_in_done_or_err", in_ready && (done || err), 0);
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit rnd);
        int guard;
        int gap;
        guard = 0;
        gap = 0;
        if (rnd) begin
            while ($urandom_range(1, 0) == 0 && gap < 6) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clk); #1;
                gap++;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 40) begin
                check("ready_timeout", in_ready, 1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input bit rnd);
        model_writes();
        for (int i = 0; i < stream.size(); i++) push_byte(stream[i], rnd);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_wea", wea, 0);
        check("rst_addra", addra, 0);
        check("rst_dina", dina, 0);
        check("rst_core_rst", core_rst, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ready", in_ready, 0);

        // N=3 program, full-rate stream
        pulse_start();
        log_data.delete(); log_addr.delete();
        stream = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        send_stream(0);
        @(negedge clk);
        check("t1_last_wea", wea, 1);
        check("t1_last_addra", addra, 2);
        check("t1_ready_in_last_write", in_ready, 1);
        check("t1_not_done_yet", done, 0);
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_core_rst", core_rst, 0);
        check("t1_ready_after", in_ready, 0);
        check("t1_nwrites", log_data.size(), 3);
        if (log_data.size() == 3) begin
            check("t1_w0", log_data[0], 32'h0000_0013);
            check("t1_w1", log_data[1], 32'h0010_0093);
            check("t1_w2", log_data[2], 32'h0000_006F);
            check("t1_a1", log_addr[1], 1);
        end
        check("t1_pending", exp_data_q.size(), 0);
        in_valid = 1'b1; in_data = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            check("t1_extra_not_ready", in_ready, 0);
        end
        in_valid = 1'b0;

        // N=0 header
        pulse_start();
        log_data.delete(); log_addr.delete();
        stream = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(0);
        @(negedge clk);
        check("t2_done", done, 1);
        check("t2_core_rst", core_rst, 0);
        check("t2_err", err, 0);
        check("t2_nwrites", log_data.size(), 0);

        // N=5 > DEPTH=4
        pulse_start();
        stream = '{8'h05, 8'h00, 8'h00, 8'h00};
        send_stream(0);
        @(negedge clk);
        check("t3_err", err, 1);
        check("t3_ready", in_ready, 0);
        check("t3_core_rst", core_rst, 1);
        check("t3_done", done, 0);
        in_valid = 1'b1; in_data = 8'h77;
        repeat (3) @(negedge clk);
        check("t3_nwrites", log_data.size(), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        pulse_start();
        @(negedge clk);
        check("t3_err_cleared", err, 0);
        check("t3_hdr_ready", in_ready, 1);
        check("t3_core_rst_held", core_rst, 1);

        // N=2 with random in_valid gaps
        pulse_start();
        log_data.delete(); log_addr.delete();
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00};
        send_stream(1);
        @(negedge clk);
        check("t4_last_wea", wea, 1);
        @(negedge clk);
        check("t4_done", done, 1);
        check("t4_nwrites", log_data.size(), 2);
        if (log_data.size() == 2) check("t4_w1", log_data[1], 32'h0010_0093);
        check("t4_pending", exp_data_q.size(), 0);

        // N == DEPTH: last write at DEPTH-1, no wrap
        pulse_start();
        log_data.delete(); log_addr.delete();
        stream = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                   8'h88, 8'h77, 8'h66, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04,
                   8'hF0, 8'hE0, 8'hD0, 8'hC0};
        send_stream(0);
        @(negedge clk);
        check("t5_last_addra", addra, 3);
        check("t5_last_dina", dina, 32'hC0D0_E0F0);
        @(negedge clk);
        check("t5_done", done, 1);
        check("t5_nwrites", log_data.size(), 4);
        if (log_data.size() == 4) check("t5_w0", log_data[0], 32'h1122_3344);

        // restart after 6 payload bytes; start collides with an offered byte
        pulse_start();
        log_data.delete(); log_addr.delete();
        stream = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        send_stream(0);
        start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_stream(0);
        @(negedge clk);
        check("t6_wea", wea, 1);
        check("t6_addra", addra, 0);
        check("t6_dina", dina, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t6_done", done, 1);
        check("t6_nwrites", log_data.size(), 2);

        // async reset mid-DATA
        pulse_start();
        stream = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
        send_stream(0);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) begin
            @(negedge clk);
            check("t7_idle_ready", in_ready, 0);
            check("t7_idle_done", done, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        pulse_start();
        log_data.delete(); log_addr.delete();
        stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        send_stream(0);
        repeat (2) @(negedge clk);
        check("t7_done", done, 1);
        check("t7_nwrites", log_data.size(), 1);
        check("t7_pending", exp_data_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
